// File: rtl/io_cs_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : io_cs_sequencer
// Purpose  : Arbitrates one peripheral I/O bus between two requesters
//            (req0 = main CPU, req1 = sub CPU). Decodes the winner's 3-bit
//            select into eight active-low chip selects and runs a fixed
//            SETUP / ACTIVE (strobe) / HOLD sequence, then pulses the
//            winner's ack for one DONE cycle.
// Ports    : clk, reset_n            clock, async active-low reset
//            en                      gates new grants only
//            reqN/selN/wrN/wdataN    requester N access request
//            ackN                    requester N completion pulse
//            rdata                   captured read data (shared)
//            cs_n/rd_n/wr_n          chip selects and strobes (active low)
//            bus_dout/bus_din        bus write / read data
//            busy, gnt               not-IDLE flag, current/last grantee
// Revision : 1.0 - initial release
// ============================================================================
module io_cs_sequencer #(
  parameter int SETUP_CYC  = 1,
  parameter int ACTIVE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       req0,
  input  logic [2:0] sel0,
  input  logic       wr0,
  input  logic [7:0] wdata0,
  output logic       ack0,
  input  logic       req1,
  input  logic [2:0] sel1,
  input  logic       wr1,
  input  logic [7:0] wdata1,
  output logic       ack1,
  output logic [7:0] rdata,
  output logic [7:0] cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic [7:0] bus_dout,
  input  logic [7:0] bus_din,
  output logic       busy,
  output logic       gnt
);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_setup  = 3'd1;
  localparam logic [2:0] c_st_active = 3'd2;
  localparam logic [2:0] c_st_hold   = 3'd3;
  localparam logic [2:0] c_st_done   = 3'd4;

  // Counters load "cycles - 1" on state entry and leave the state at zero.
  localparam logic [3:0] c_setup_load  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] c_active_load = 4'(ACTIVE_CYC - 1);
  localparam logic [3:0] c_hold_load   = 4'(HOLD_CYC - 1);

  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       w_grant;
  logic       w_winner;

  // Latched access attributes
  logic [2:0] sel_q, sel_d;
  logic       wr_q, wr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       gnt_q, gnt_d;
  logic       last_q, last_d;

  // Registered outputs
  logic [7:0] cs_n_q, cs_n_d;
  logic       rd_n_q, rd_n_d;
  logic       wr_n_q, wr_n_d;
  logic [7:0] bus_dout_q, bus_dout_d;
  logic [7:0] rdata_q, rdata_d;
  logic       ack0_q, ack0_d;
  logic       ack1_q, ack1_d;
  logic       busy_q, busy_d;
  logic       w_cs_phase;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= c_st_idle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic, including the round-robin grant decision
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    w_grant  = 1'b0;
    w_winner = gnt_q;
    case (state_q)
      c_st_idle: begin
        if (en && (req0 || req1)) begin
          w_grant = 1'b1;
          // On a tie the requester that did not win last time goes next.
          w_winner = (req0 && req1) ? ~last_q : req1;
          state_d  = c_st_setup;
          cnt_d    = c_setup_load;
        end
      end
      c_st_setup: begin
        if (cnt_q == 4'd0) begin
          state_d = c_st_active;
          cnt_d   = c_active_load;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      c_st_active: begin
        if (cnt_q == 4'd0) begin
          state_d = c_st_hold;
          cnt_d   = c_hold_load;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      c_st_hold: begin
        if (cnt_q == 4'd0) begin
          state_d = c_st_done;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      c_st_done: begin
        state_d = c_st_idle;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = c_st_idle;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic. Outputs are computed from the *next* state and next latched
  // attributes so that the registered copies line up with the state they
  // describe (cs_n drops in the first SETUP cycle, not one cycle later).
  // --------------------------------------------------------------------------
  always_comb begin
    sel_d   = sel_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    if (w_grant) begin
      sel_d   = w_winner ? sel1   : sel0;
      wr_d    = w_winner ? wr1    : wr0;
      wdata_d = w_winner ? wdata1 : wdata0;
      gnt_d   = w_winner;
      last_d  = w_winner;
    end

    w_cs_phase = (state_d == c_st_setup) || (state_d == c_st_active) ||
                 (state_d == c_st_hold);

    cs_n_d     = w_cs_phase ? ~(8'h01 << sel_d) : 8'hFF;
    rd_n_d     = !((state_d == c_st_active) && !wr_d);
    wr_n_d     = !((state_d == c_st_active) &&  wr_d);
    bus_dout_d = (w_cs_phase && wr_d) ? wdata_d : 8'h00;
    ack0_d     = (state_d == c_st_done) && !gnt_d;
    ack1_d     = (state_d == c_st_done) &&  gnt_d;
    busy_d     = (state_d != c_st_idle);

    // Read data is sampled on the edge that ends the last ACTIVE cycle.
    rdata_d = rdata_q;
    if ((state_q == c_st_active) && (cnt_q == 4'd0) && !wr_q) begin
      rdata_d = bus_din;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_q      <= 3'd0;
      wr_q       <= 1'b0;
      wdata_q    <= 8'h00;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;  // requester 0 wins the first tie
      cs_n_q     <= 8'hFF;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      bus_dout_q <= 8'h00;
      rdata_q    <= 8'h00;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sel_q      <= sel_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      cs_n_q     <= cs_n_d;
      rd_n_q     <= rd_n_d;
      wr_n_q     <= wr_n_d;
      bus_dout_q <= bus_dout_d;
      rdata_q    <= rdata_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      busy_q     <= busy_d;
    end
  end

  assign cs_n     = cs_n_q;
  assign rd_n     = rd_n_q;
  assign wr_n     = wr_n_q;
  assign bus_dout = bus_dout_q;
  assign rdata    = rdata_q;
  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign busy     = busy_q;
  assign gnt      = gnt_q;

endmodule
`default_nettype wire

// File: tb/tb_io_cs_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_cs_sequencer
// Purpose  : Self-checking bench for io_cs_sequencer. A default-timing DUT is
//            compared every cycle against an access-offset model; a second
//            instance with SETUP=3/ACTIVE=1/HOLD=2 checks parameterised timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_cs_sequencer;

  localparam int S  = 1;
  localparam int A  = 2;
  localparam int H  = 1;
  localparam int N  = S + A + H;
  localparam int PS = 3;
  localparam int PA = 1;
  localparam int PH = 2;

  logic       clk = 1'b0;
  logic       reset_n, en;
  logic       req0, wr0, req1, wr1;
  logic [2:0] sel0, sel1;
  logic [7:0] wdata0, wdata1, bus_din;
  logic       ack0, ack1, rd_n, wr_n, busy, gnt;
  logic [7:0] rdata, cs_n, bus_dout;

  logic       p_req0, p_req1;
  logic       p_ack0, p_ack1, p_rd_n, p_wr_n, p_busy, p_gnt;
  logic [7:0] p_rdata, p_cs_n, p_bus_dout;

  int checks = 0;
  int errors = 0;

  // Access-level reference model: m_k is the 1-based cycle index inside the
  // current access (1..N cs cycles, N+1 = ack cycle).
  bit         m_busy, m_gnt, m_last, m_wr;
  int         m_k;
  logic [2:0] m_sel;
  logic [7:0] m_wdata, m_rdata;

  always #5 clk = ~clk;

  io_cs_sequencer dut (
    .clk(clk), .reset_n(reset_n), .en(en),
    .req0(req0), .sel0(sel0), .wr0(wr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .sel1(sel1), .wr1(wr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
    .bus_dout(bus_dout), .bus_din(bus_din), .busy(busy), .gnt(gnt)
  );

  io_cs_sequencer #(.SETUP_CYC(PS), .ACTIVE_CYC(PA), .HOLD_CYC(PH)) dut_p (
    .clk(clk), .reset_n(reset_n), .en(en),
    .req0(p_req0), .sel0(sel0), .wr0(wr0), .wdata0(wdata0), .ack0(p_ack0),
    .req1(p_req1), .sel1(sel1), .wr1(wr1), .wdata1(wdata1), .ack1(p_ack1),
    .rdata(p_rdata), .cs_n(p_cs_n), .rd_n(p_rd_n), .wr_n(p_wr_n),
    .bus_dout(p_bus_dout), .bus_din(bus_din), .busy(p_busy), .gnt(p_gnt)
  );

  task automatic model_reset();
    m_busy  = 1'b0;
    m_k     = 0;
    m_gnt   = 1'b0;
    m_last  = 1'b1;
    m_wr    = 1'b0;
    m_sel   = 3'd0;
    m_wdata = 8'h00;
    m_rdata = 8'h00;
  endtask

  // One clock: advance the model at the edge, compare the default DUT at the
  // following falling edge.
  task automatic step();
    logic [7:0] onehot, e_cs, e_dout;
    bit         cs_on, strobe, e_rd_n, e_wr_n, e_a0, e_a1, win;
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else if (m_busy) begin
      if (m_k == S + A && !m_wr) m_rdata = bus_din;
      if (m_k == N + 1) m_busy = 1'b0;
      else m_k = m_k + 1;
    end else if (en && (req0 || req1)) begin
      if (req0 && req1) win = !m_last;
      else win = req1;
      m_sel   = win ? sel1 : sel0;
      m_wr    = win ? wr1 : wr0;
      m_wdata = win ? wdata1 : wdata0;
      m_gnt   = win;
      m_last  = win;
      m_busy  = 1'b1;
      m_k     = 1;
    end
    @(negedge clk);
    cs_on  = m_busy && (m_k <= N);
    strobe = m_busy && (m_k > S) && (m_k <= S + A);
    onehot = 8'h01 << m_sel;
    e_cs   = cs_on ? ~onehot : 8'hFF;
    e_dout = (cs_on && m_wr) ? m_wdata : 8'h00;
    e_rd_n = !(strobe && !m_wr);
    e_wr_n = !(strobe && m_wr);
    e_a0   = m_busy && (m_k == N + 1) && !m_gnt;
    e_a1   = m_busy && (m_k == N + 1) && m_gnt;
    checks++;
    if (cs_n !== e_cs) begin
      errors++; $display("FAIL model cs_n: got %h expected %h t=%0t", cs_n, e_cs, $time);
    end
    checks++;
    if ({rd_n, wr_n} !== {e_rd_n, e_wr_n}) begin
      errors++; $display("FAIL model rd_n/wr_n: got %b%b expected %b%b t=%0t",
                         rd_n, wr_n, e_rd_n, e_wr_n, $time);
    end
    checks++;
    if (bus_dout !== e_dout) begin
      errors++; $display("FAIL model bus_dout: got %h expected %h t=%0t", bus_dout, e_dout, $time);
    end
    checks++;
    if (rdata !== m_rdata) begin
      errors++; $display("FAIL model rdata: got %h expected %h t=%0t", rdata, m_rdata, $time);
    end
    checks++;
    if ({ack0, ack1, busy, gnt} !== {e_a0, e_a1, m_busy, m_gnt}) begin
      errors++; $display("FAIL model ack0/ack1/busy/gnt: got %b%b%b%b expected %b%b%b%b t=%0t",
                         ack0, ack1, busy, gnt, e_a0, e_a1, m_busy, m_gnt, $time);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    step();
    step();
    checks++;
    if ({cs_n, rd_n, wr_n, bus_dout, rdata, ack0, ack1, busy, gnt} !==
        {8'hFF, 1'b1, 1'b1, 8'h00, 8'h00, 4'b0000}) begin
      errors++; $display("FAIL reset state: cs_n=%h rd_n=%b wr_n=%b dout=%h rdata=%h acks=%b%b busy=%b gnt=%b",
                         cs_n, rd_n, wr_n, bus_dout, rdata, ack0, ack1, busy, gnt);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single_read();
    en = 1'b1; req0 = 1'b1; sel0 = 3'd3; wr0 = 1'b0; bus_din = 8'hA5;
    for (int c = 1; c <= 6; c++) begin
      step();
      checks++;
      if (cs_n !== ((c <= 4) ? 8'hF7 : 8'hFF)) begin
        errors++; $display("FAIL read cs_n cycle %0d: got %h", c, cs_n);
      end
      checks++;
      if (rd_n !== !(c == 2 || c == 3)) begin
        errors++; $display("FAIL read rd_n cycle %0d: got %b", c, rd_n);
      end
      checks++;
      if (ack0 !== (c == 5)) begin
        errors++; $display("FAIL read ack0 cycle %0d: got %b", c, ack0);
      end
      if (c >= 4) begin
        checks++;
        if (rdata !== 8'hA5) begin
          errors++; $display("FAIL read rdata cycle %0d: got %h expected a5", c, rdata);
        end
      end
      if (c == 5) req0 = 1'b0;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL read busy after DONE: got %b expected 0", busy);
    end
  endtask

  task automatic test_single_write();
    req1 = 1'b1; sel1 = 3'd7; wr1 = 1'b1; wdata1 = 8'h3C; bus_din = 8'h11;
    for (int c = 1; c <= 6; c++) begin
      step();
      checks++;
      if (cs_n !== ((c <= 4) ? 8'h7F : 8'hFF)) begin
        errors++; $display("FAIL write cs_n cycle %0d: got %h", c, cs_n);
      end
      checks++;
      if ({wr_n, rd_n} !== {!(c == 2 || c == 3), 1'b1}) begin
        errors++; $display("FAIL write strobes cycle %0d: got wr_n=%b rd_n=%b", c, wr_n, rd_n);
      end
      checks++;
      if (bus_dout !== ((c <= 4) ? 8'h3C : 8'h00)) begin
        errors++; $display("FAIL write bus_dout cycle %0d: got %h", c, bus_dout);
      end
      checks++;
      if ({ack1, ack0} !== {(c == 5), 1'b0}) begin
        errors++; $display("FAIL write acks cycle %0d: got ack1=%b ack0=%b", c, ack1, ack0);
      end
      checks++;
      if (rdata !== 8'hA5) begin
        errors++; $display("FAIL write rdata changed cycle %0d: got %h expected a5", c, rdata);
      end
      if (c == 5) req1 = 1'b0;
    end
  endtask

  task automatic test_contention();
    int  order[$];
    bit  prev_ack;
    wr0 = 1'b0; wr1 = 1'b1; sel0 = 3'd1; sel1 = 3'd6;
    wdata0 = 8'h00; wdata1 = 8'h5A;
    req0 = 1'b1; req1 = 1'b1; prev_ack = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      step();
      checks++;
      if ($countones(~cs_n) > 1) begin
        errors++; $display("FAIL contention cs_n multiple low: got %h", cs_n);
      end
      if (prev_ack) begin
        checks++;
        if ({busy, cs_n} !== {1'b0, 8'hFF}) begin
          errors++; $display("FAIL contention idle gap: got busy=%b cs_n=%h", busy, cs_n);
        end
      end
      prev_ack = ack0 | ack1;
      if (ack0 && ack1) begin
        checks++; errors++;
        $display("FAIL contention both acks: got 11 expected one");
      end
      if (ack0) order.push_back(0);
      if (ack1) order.push_back(1);
      if (c == 23) begin req0 = 1'b0; req1 = 1'b0; end
    end
    checks++;
    if (order.size() != 4) begin
      errors++; $display("FAIL contention ack count: got %0d expected 4", order.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (order[i] != (i % 2)) begin
          errors++; $display("FAIL contention grant %0d: got %0d expected %0d", i, order[i], i % 2);
        end
      end
    end
  endtask

  task automatic test_enable();
    bit done;
    en = 1'b0; req0 = 1'b1; sel0 = 3'd5; wr0 = 1'b1; wdata0 = 8'($urandom);
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if ({cs_n, busy} !== {8'hFF, 1'b0}) begin
        errors++; $display("FAIL enable gated: got cs_n=%h busy=%b", cs_n, busy);
      end
    end
    en = 1'b1;
    step();
    checks++;
    if (cs_n !== 8'hDF) begin
      errors++; $display("FAIL enable grant: got cs_n=%h expected df", cs_n);
    end
    step();
    en = 1'b0;  // drop en mid-ACTIVE
    done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      step();
      if (ack0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL enable ack after en drop: got no ack0 expected ack0");
    end
    req0 = 1'b0;
    req1 = 1'b1; sel1 = 3'd2; wr1 = 1'b0; bus_din = 8'($urandom);
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (busy !== 1'b0) begin
        errors++; $display("FAIL enable pending wait: got busy=%b expected 0", busy);
      end
    end
    en = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 12 && !done; c++) begin
      step();
      if (ack1) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL enable resume: got no ack1 expected ack1");
    end
    req1 = 1'b0;
    step();
  endtask

  task automatic test_params();
    logic [2:0] s;
    logic [7:0] din, onehot;
    s = 3'($urandom); din = 8'($urandom);
    onehot = 8'h01 << s;
    en = 1'b1; sel0 = s; wr0 = 1'b0; bus_din = din; p_req0 = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      checks++;
      if (p_cs_n !== ((c <= PS + PA + PH) ? ~onehot : 8'hFF)) begin
        errors++; $display("FAIL params cs_n cycle %0d: got %h", c, p_cs_n);
      end
      checks++;
      if (p_rd_n !== !(c == PS + 1)) begin
        errors++; $display("FAIL params rd_n cycle %0d: got %b", c, p_rd_n);
      end
      checks++;
      if (p_ack0 !== (c == PS + PA + PH + 1)) begin
        errors++; $display("FAIL params ack0 cycle %0d: got %b", c, p_ack0);
      end
      if (c == 7) p_req0 = 1'b0;
    end
    checks++;
    if ({p_rdata, p_busy} !== {din, 1'b0}) begin
      errors++; $display("FAIL params rdata/busy: got %h/%b expected %h/0", p_rdata, p_busy, din);
    end
  endtask

  task automatic test_async_reset();
    bit done;
    en = 1'b1; req0 = 1'b1; sel0 = 3'($urandom); wr0 = 1'b0;
    step();
    step();  // now in ACTIVE with rd_n low
    #1 reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({cs_n, rd_n, wr_n, ack0, ack1, busy, gnt, rdata} !==
        {8'hFF, 1'b1, 1'b1, 4'b0000, 8'h00}) begin
      errors++; $display("FAIL async reset: got cs_n=%h rd_n=%b wr_n=%b acks=%b%b busy=%b gnt=%b rdata=%h",
                         cs_n, rd_n, wr_n, ack0, ack1, busy, gnt, rdata);
    end
    req0 = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    req0 = 1'b1; req1 = 1'b1; wr1 = 1'b1;
    step();
    checks++;
    if (gnt !== 1'b0) begin
      errors++; $display("FAIL reset first tie: got gnt=%b expected 0", gnt);
    end
    done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      step();
      if (ack0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL reset tie ack: got no ack0 expected ack0");
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
  endtask

  task automatic test_random();
    int n_acks;
    n_acks = 0;
    en = 1'b1;
    for (int c = 0; c < 800; c++) begin
      bus_din = 8'($urandom);
      if (ack0 || ack1) n_acks++;
      if (req0 && ack0) req0 = 1'b0;
      else if (!req0 && $urandom_range(0, 3) == 0) begin
        req0 = 1'b1; sel0 = 3'($urandom); wr0 = 1'($urandom); wdata0 = 8'($urandom);
      end
      if (req1 && ack1) req1 = 1'b0;
      else if (!req1 && $urandom_range(0, 3) == 0) begin
        req1 = 1'b1; sel1 = 3'($urandom); wr1 = 1'($urandom); wdata1 = 8'($urandom);
      end
      if ($urandom_range(0, 15) == 0) en = ~en;
      step();
    end
    en = 1'b1;
    for (int c = 0; c < 40 && (req0 || req1); c++) begin
      if (req0 && ack0) req0 = 1'b0;
      if (req1 && ack1) req1 = 1'b0;
      step();
    end
    checks++;
    if (req0 || req1) begin
      errors++; $display("FAIL random drain: got pending req0=%b req1=%b expected none", req0, req1);
    end
    checks++;
    if (n_acks < 20) begin
      errors++; $display("FAIL random progress: got %0d acks expected at least 20", n_acks);
    end
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b0;
    req0 = 1'b0; sel0 = 3'd0; wr0 = 1'b0; wdata0 = 8'h00;
    req1 = 1'b0; sel1 = 3'd0; wr1 = 1'b0; wdata1 = 8'h00;
    bus_din = 8'h00; p_req0 = 1'b0; p_req1 = 1'b0;
    model_reset();
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_enable();
    test_params();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
